// File: rtl/pipe_exec_ctrl_pkg.sv
// Shared types for the pipeline execution sequencer: command codes, FSM states, defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_exec_ctrl_pkg;

  // Debug-unit command encoding
  typedef enum logic [1:0] {
    CMD_STOP  = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  // Sequencer states; the numeric codes are visible to the debug unit on o_state
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  localparam int CNTW_DEF         = 32;
  localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/pipe_exec_ctrl_if.sv
// Command handshake, decode halt input and pipeline-control outputs of the execution sequencer.
// Latency: n/a (wiring only).
// Backpressure: o_cmd_ready from the sequencer qualifies i_cmd_valid.
interface pipe_exec_ctrl_if #(
  parameter int CNTW = 32
);
  logic            i_cmd_valid;
  logic [1:0]      i_cmd;
  logic            o_cmd_ready;
  logic            i_halt_detected;
  logic            o_pipe_en;
  logic            o_pc_en;
  logic            o_if_flush;
  logic            o_done;
  logic            o_cmd_err;
  logic            o_halted;
  logic [2:0]      o_state;
  logic [CNTW-1:0] o_cycle_cnt;

  // Debug unit / decode side
  modport master (
    output i_cmd_valid, i_cmd, i_halt_detected,
    input  o_cmd_ready, o_pipe_en, o_pc_en, o_if_flush, o_done,
           o_cmd_err, o_halted, o_state, o_cycle_cnt
  );

  // Sequencer side
  modport slave (
    input  i_cmd_valid, i_cmd, i_halt_detected,
    output o_cmd_ready, o_pipe_en, o_pc_en, o_if_flush, o_done,
           o_cmd_err, o_halted, o_state, o_cycle_cnt
  );
endinterface

// File: rtl/pipe_exec_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: q updates on the edge where en or clr is sampled.
// Backpressure: none; clr has priority over en, count holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise increment until all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + W'(1);
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign q = cnt_q;
endmodule

// File: rtl/pipe_exec_ctrl.sv
// Execution sequencer: gates PC/pipeline enables for RUN/STEP/STOP and drains the pipe on HALT.
// Latency: enables are Moore on state (pc_en/if_flush also see halt combinationally); done/err one cycle after cause.
// Backpressure: o_cmd_ready drops in STEP and DRAIN, commands are only taken in IDLE/RUN/HALTED.
module pipe_exec_ctrl
  import pipe_exec_ctrl_pkg::*;
#(
  parameter int CNTW         = CNTW_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input logic            i_clk,
  input logic            i_rst_n,
  pipe_exec_ctrl_if.slave bus
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e          state_q, state_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            cnt_clr;
  logic            cmd_ready;
  logic            accept;
  logic            active;
  logic            pipe_en;
  cmd_e            cmd;
  logic [CNTW-1:0] cnt;

  assign cmd = cmd_e'(bus.i_cmd);

  // Moore decode of state-only outputs
  always_comb begin
    cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_HALTED);
    active    = (state_q == ST_RUN) || (state_q == ST_STEP);
    pipe_en   = active || (state_q == ST_DRAIN);
  end

  assign accept = bus.i_cmd_valid && cmd_ready;

  // Next-state logic; a halt seen in RUN/STEP takes priority over any command that cycle
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_RUN:   state_d = ST_RUN;
            CMD_STEP:  state_d = ST_STEP;
            CMD_CLEAR: cnt_clr = 1'b1;
            default:   state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (bus.i_halt_detected) begin
          state_d = ST_DRAIN;
          drain_d = DW'(DRAIN_CYCLES - 1);
        end else if (accept) begin
          if (cmd == CMD_STOP)
            state_d = ST_IDLE;
          else
            err_d = 1'b1;
        end
      end
      ST_STEP: begin
        if (bus.i_halt_detected) begin
          state_d = ST_DRAIN;
          drain_d = DW'(DRAIN_CYCLES - 1);
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      ST_HALTED: begin
        if (accept) begin
          if (cmd == CMD_CLEAR) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, drain counter and registered pulse outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(.W(CNTW)) u_cycle_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .en    (pipe_en),
    .clr   (cnt_clr),
    .q     (cnt)
  );

  assign bus.o_cmd_ready = cmd_ready;
  assign bus.o_pipe_en   = pipe_en;
  assign bus.o_pc_en     = active && !bus.i_halt_detected;
  assign bus.o_if_flush  = active && bus.i_halt_detected;
  assign bus.o_done      = done_q;
  assign bus.o_cmd_err   = err_q;
  assign bus.o_halted    = (state_q == ST_HALTED);
  assign bus.o_state     = state_q;
  assign bus.o_cycle_cnt = cnt;
endmodule

// File: tb/tb_pipe_exec_ctrl.sv
// Bench for pipe_exec_ctrl: 32-bit and 4-bit counter instances share one stimulus stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_exec_ctrl;
  logic clk;
  logic rst_n;

  pipe_exec_ctrl_if #(.CNTW(32)) bus ();
  pipe_exec_ctrl_if #(.CNTW(4))  bus4 ();

  assign bus4.i_cmd_valid     = bus.i_cmd_valid;
  assign bus4.i_cmd           = bus.i_cmd;
  assign bus4.i_halt_detected = bus.i_halt_detected;

  pipe_exec_ctrl #(.CNTW(32), .DRAIN_CYCLES(3)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  pipe_exec_ctrl #(.CNTW(4), .DRAIN_CYCLES(3)) dut4 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [2:0]  st;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp)
      passed++;
    else
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input bit d, input logic [2:0] s, input logic [31:0] c, input logic [3:0] c4);
    exp_t ne;
    ne.is_done = d;
    ne.st      = s;
    ne.cnt     = c;
    ne.cnt4    = c4;
    exp_q.push_back(ne);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cmd(input logic [1:0] c);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = c;
  endtask

  task automatic idle();
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd       = 2'b00;
  endtask

  // Monitor: every done/err pulse must match the oldest expected event
  always @(negedge clk) begin
    if (rst_n && (bus.o_done || bus.o_cmd_err)) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pulse: done=%0b err=%0b state=%0d, expected no pulse",
                 bus.o_done, bus.o_cmd_err, bus.o_state);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_kind{done,err}", {30'd0, bus.o_done, bus.o_cmd_err},
            mon_e.is_done ? 32'd2 : 32'd1);
        chk("pulse_state", {29'd0, bus.o_state}, {29'd0, mon_e.st});
        chk("pulse_cnt", bus.o_cycle_cnt, mon_e.cnt);
        chk("pulse_cnt4", {28'd0, bus4.o_cycle_cnt}, {28'd0, mon_e.cnt4});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd = 2'b00;
    bus.i_halt_detected = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_state", {29'd0, bus.o_state}, 32'd0);
    chk("rst_ready", {31'd0, bus.o_cmd_ready}, 32'd1);
    chk("rst_pipe_en", {31'd0, bus.o_pipe_en}, 32'd0);
    chk("rst_pc_en", {31'd0, bus.o_pc_en}, 32'd0);
    chk("rst_flush", {31'd0, bus.o_if_flush}, 32'd0);
    chk("rst_done", {31'd0, bus.o_done}, 32'd0);
    chk("rst_err", {31'd0, bus.o_cmd_err}, 32'd0);
    chk("rst_halted", {31'd0, bus.o_halted}, 32'd0);
    chk("rst_cnt", bus.o_cycle_cnt, 32'd0);
    rst_n = 1'b1;
    tick();

    // STOP in IDLE: accepted, nothing happens
    cmd(2'b00); tick(); idle();
    chk("idle_stop_state", {29'd0, bus.o_state}, 32'd0);
    chk("idle_stop_cnt", bus.o_cycle_cnt, 32'd0);

    // RUN, halt in the 10th RUN cycle, 3 DRAIN cycles, HALTED with cnt 13
    cmd(2'b01); tick(); idle();
    chk("run_state", {29'd0, bus.o_state}, 32'd1);
    chk("run_pc_en", {31'd0, bus.o_pc_en}, 32'd1);
    chk("run_ready", {31'd0, bus.o_cmd_ready}, 32'd1);
    repeat (9) tick();
    bus.i_halt_detected = 1'b1;
    #1;
    chk("halt_pc_en", {31'd0, bus.o_pc_en}, 32'd0);
    chk("halt_flush", {31'd0, bus.o_if_flush}, 32'd1);
    chk("halt_pipe_en", {31'd0, bus.o_pipe_en}, 32'd1);
    push(1'b1, 3'd4, 32'd13, 4'd13);
    tick();
    bus.i_halt_detected = 1'b0;
    chk("drain_state", {29'd0, bus.o_state}, 32'd3);
    chk("drain_ready", {31'd0, bus.o_cmd_ready}, 32'd0);
    chk("drain_pipe_en", {31'd0, bus.o_pipe_en}, 32'd1);
    chk("drain_pc_en", {31'd0, bus.o_pc_en}, 32'd0);
    repeat (2) tick();
    chk("drain3_state", {29'd0, bus.o_state}, 32'd3);
    tick();
    chk("halted_state", {29'd0, bus.o_state}, 32'd4);
    chk("halted_flag", {31'd0, bus.o_halted}, 32'd1);
    chk("halted_pipe_en", {31'd0, bus.o_pipe_en}, 32'd0);
    chk("halted_ready", {31'd0, bus.o_cmd_ready}, 32'd1);
    tick();
    chk("done_one_cycle", {31'd0, bus.o_done}, 32'd0);
    chk("halted_cnt_hold", bus.o_cycle_cnt, 32'd13);

    // RUN while HALTED: error, stay; then CLEAR back to IDLE with zero count
    cmd(2'b01); push(1'b0, 3'd4, 32'd13, 4'd13); tick(); idle();
    chk("halted_run_state", {29'd0, bus.o_state}, 32'd4);
    tick();
    chk("err_one_cycle", {31'd0, bus.o_cmd_err}, 32'd0);
    cmd(2'b11); tick(); idle();
    chk("clear_state", {29'd0, bus.o_state}, 32'd0);
    chk("clear_cnt", bus.o_cycle_cnt, 32'd0);
    chk("clear_cnt4", {28'd0, bus4.o_cycle_cnt}, 32'd0);

    // Three single steps
    for (int k = 1; k <= 3; k++) begin
      cmd(2'b10); push(1'b1, 3'd0, k, 4'(k)); tick(); idle();
      chk("step_state", {29'd0, bus.o_state}, 32'd2);
      chk("step_ready", {31'd0, bus.o_cmd_ready}, 32'd0);
      chk("step_pipe_en", {31'd0, bus.o_pipe_en}, 32'd1);
      tick();
      chk("step_back_idle", {29'd0, bus.o_state}, 32'd0);
      chk("step_idle_pipe_en", {31'd0, bus.o_pipe_en}, 32'd0);
    end
    chk("step_cnt", bus.o_cycle_cnt, 32'd3);

    // STEP with halt in the same cycle: drain, single done at HALTED
    cmd(2'b10); tick(); idle();
    bus.i_halt_detected = 1'b1;
    #1;
    chk("step_halt_flush", {31'd0, bus.o_if_flush}, 32'd1);
    chk("step_halt_pc_en", {31'd0, bus.o_pc_en}, 32'd0);
    push(1'b1, 3'd4, 32'd7, 4'd7);
    tick();
    bus.i_halt_detected = 1'b0;
    chk("step_drain_state", {29'd0, bus.o_state}, 32'd3);
    repeat (2) tick();
    chk("step_drain3_state", {29'd0, bus.o_state}, 32'd3);
    tick();
    chk("step_halted_state", {29'd0, bus.o_state}, 32'd4);
    tick();
    chk("step_done_once", {31'd0, bus.o_done}, 32'd0);

    // CLEAR, RUN, then RUN again while running: error, stay RUN
    cmd(2'b11); tick();
    chk("clear2_cnt", bus.o_cycle_cnt, 32'd0);
    cmd(2'b01); tick();
    push(1'b0, 3'd1, 32'd1, 4'd1);
    tick(); idle();
    chk("run_run_state", {29'd0, bus.o_state}, 32'd1);

    // Saturation of the 4-bit instance
    repeat (20) tick();
    chk("sat_cnt32", bus.o_cycle_cnt, 32'd21);
    chk("sat_cnt4", {28'd0, bus4.o_cycle_cnt}, 32'd15);

    // STOP with halt in the same cycle: halt wins, no error
    cmd(2'b00);
    bus.i_halt_detected = 1'b1;
    push(1'b1, 3'd4, 32'd25, 4'd15);
    tick(); idle();
    bus.i_halt_detected = 1'b0;
    chk("stop_halt_state", {29'd0, bus.o_state}, 32'd3);
    repeat (2) tick();
    tick();
    chk("stop_halt_halted", {29'd0, bus.o_state}, 32'd4);
    tick();

    // Asynchronous reset in the middle of DRAIN
    cmd(2'b11); tick();
    cmd(2'b01); tick(); idle();
    repeat (2) tick();
    bus.i_halt_detected = 1'b1;
    tick();
    bus.i_halt_detected = 1'b0;
    tick();
    chk("pre_reset_drain", {29'd0, bus.o_state}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", {29'd0, bus.o_state}, 32'd0);
    chk("arst_pipe_en", {31'd0, bus.o_pipe_en}, 32'd0);
    chk("arst_cnt", bus.o_cycle_cnt, 32'd0);
    chk("arst_cnt4", {28'd0, bus4.o_cycle_cnt}, 32'd0);
    chk("arst_ready", {31'd0, bus.o_cmd_ready}, 32'd1);
    chk("arst_halted", {31'd0, bus.o_halted}, 32'd0);
    repeat (2) tick();

    chk("pending_pulses", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
